// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared write-back datapath widths and default sequencing constants
package wb_pkg;

  localparam int WB_WIDTH      = 32;
  localparam int WB_NSRC       = 4;
  localparam int WB_SELW       = 2;
  localparam int WB_PERIOD     = 10;
  localparam int WB_FIRE_PHASE = 5;
  localparam int WB_PHASE_W    = 4;

  // Index width able to address the base of every selectable source, in range or not.
  function automatic int base_idx_w(input int selw, input int width);
    return $clog2((2 ** selw) * width);
  endfunction

endpackage

// File: rtl/phase_ctr.sv
// rtl/phase_ctr.sv - modulo-PERIOD phase counter with stall, synchronous clear and fire decode
module phase_ctr
  import wb_pkg::*;
#(
  parameter int PERIOD     = WB_PERIOD,
  parameter int FIRE_PHASE = WB_FIRE_PHASE
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_sync_clear,
  output logic [WB_PHASE_W-1:0] o_phase,
  output logic                  o_fire
);

  logic [WB_PHASE_W-1:0] r_phase;
  logic                  w_wrap;

  assign w_wrap = (r_phase == WB_PHASE_W'(PERIOD - 1));
  // Clear outranks fire, so a cleared edge never produces an output update.
  assign o_fire = i_enable && !i_sync_clear && (r_phase == WB_PHASE_W'(FIRE_PHASE));
  assign o_phase = r_phase;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
    end else if (i_sync_clear) begin
      r_phase <= '0;
    end else if (i_enable) begin
      r_phase <= w_wrap ? '0 : r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/wb_select_seq.sv
// rtl/wb_select_seq.sv - phase-sequenced write-back source select with registered output
module wb_select_seq
  import wb_pkg::*;
#(
  parameter int WIDTH      = WB_WIDTH,
  parameter int NSRC       = WB_NSRC,
  parameter int SELW       = WB_SELW,
  parameter int PERIOD     = WB_PERIOD,
  parameter int FIRE_PHASE = WB_FIRE_PHASE
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_sync_clear,
  input  logic [SELW-1:0]       i_sel,
  input  logic [NSRC*WIDTH-1:0] i_src_data,
  output logic [WIDTH-1:0]      o_out_data,
  output logic                  o_out_valid,
  output logic [WB_PHASE_W-1:0] o_phase,
  output logic                  o_sel_err
);

  localparam int IDXW = base_idx_w(SELW, WIDTH);

  logic [NSRC*WIDTH-1:0] r_src;
  logic [SELW-1:0]       r_sel;
  logic [WIDTH-1:0]      r_data;
  logic                  r_valid;
  logic                  r_sel_err;

  logic                  w_fire;
  logic                  w_sel_ok;
  logic [IDXW-1:0]       w_base;
  logic [WIDTH-1:0]      w_sel_data;

  phase_ctr #(
    .PERIOD     (PERIOD),
    .FIRE_PHASE (FIRE_PHASE)
  ) u_phase_ctr (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_enable     (i_enable),
    .i_sync_clear (i_sync_clear),
    .o_phase      (o_phase),
    .o_fire       (w_fire)
  );

  // Selection works on the captured copy, so the fired value is the one from the prior edge.
  assign w_sel_ok   = (32'(r_sel) < NSRC);
  assign w_base     = IDXW'(r_sel) * IDXW'(WIDTH);
  assign w_sel_data = w_sel_ok ? r_src[w_base +: WIDTH] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src     <= '0;
      r_sel     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_src   <= i_src_data;
      r_sel   <= i_sel;
      r_valid <= w_fire;
      if (w_fire) begin
        r_data <= w_sel_data;
        if (!w_sel_ok) begin
          r_sel_err <= 1'b1;
        end
      end
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_sel_err   = r_sel_err;

endmodule
